sync_fifo_param: RTL

- Single-clock, parametrised FIFO; the successor to the dual-clock FIFO used in the current test environment.
- Adds configurable data width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, a read-valid strobe, and defined behaviour when read and write occur together at full or empty.
- Sits between producer and consumer blocks in the same clock domain.
- Its status semantics (overflow, underflow, empty, full, rdata hold) match those the existing assertion module checks, so the current bench carries over.

---
 rtl/sync_fifo_param_pkg.sv | 24 ++
 rtl/sync_fifo_param_if.sv | 56 +++++
 rtl/sync_fifo_param_mem.sv | 45 ++++
 rtl/sync_fifo_param.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sync_fifo_param_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for sync_fifo_param:
//   - ptr_w(depth)  : pointer/count width, $clog2(depth)+1 (MSB is the wrap bit)
//   - fifo_err_e    : error classification for scoreboards
//   - DEF_*         : default parameter values
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_DEPTH    = 16;
    localparam int unsigned DEF_AE_LEVEL = 2;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_OVF,
        ERR_UNF
    } fifo_err_e;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
// Bus bundle between the FIFO and its producer/consumer.
//   master : drives wr_en, wdata, rd_en (and err_clr), observes data/status
//   slave  : the FIFO side; drives rdata, rd_valid and all status flags
// Optional macro FIFO_STICKY_ERR_EN adds the err_clr signal.
// -----------------------------------------------------------------------------
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
);
    localparam int unsigned CntW = ptr_w(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wdata;
    logic              rd_en;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CntW-1:0]   count;
    logic              overflow;
    logic              underflow;
`ifdef FIFO_STICKY_ERR_EN
    logic              err_clr;

    modport master (
        output wr_en, wdata, rd_en, err_clr,
        input  rdata, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wdata, rd_en, err_clr,
        output rdata, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
`else
    modport master (
        output wr_en, wdata, rd_en,
        input  rdata, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wdata, rd_en,
        output rdata, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
`endif

endinterface

// File: rtl/sync_fifo_param_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port RAM, DEPTH x DATA_W.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (read register only)
//   i_we, i_waddr, i_wdata : synchronous write port
//   i_re, i_raddr, o_rdata : synchronous read port; o_rdata holds when !i_re
// Array contents are never reset. A read and write to the same address in one
// cycle returns the old contents.
// -----------------------------------------------------------------------------
module fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned AddrW = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [AddrW-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AddrW-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock parametrised FIFO with occupancy count, almost-full/empty
// thresholds, read-valid strobe and overflow/underflow reporting.
// Ports:
//   clk      : clock, rising edge
//   res_n    : async active-low reset (synchronous release expected)
//   fifo_bus : sync_fifo_param_if.slave (wr_en, wdata, rd_en, rdata, rd_valid,
//              full, empty, almost_full, almost_empty, count, overflow,
//              underflow, and err_clr when FIFO_STICKY_ERR_EN is defined)
// Macro FIFO_STICKY_ERR_EN: overflow/underflow become sticky until err_clr.
// Read latency is one cycle; all flags are registered from next-state values.
// -----------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic                    clk,
    input  logic                    res_n,
    sync_fifo_param_if.slave        fifo_bus
);

    localparam int unsigned PtrW  = ptr_w(DEPTH);
    localparam int unsigned AddrW = PtrW - 1;
    localparam logic [PtrW-1:0] AfLvl  = PtrW'(AF_LEVEL);
    localparam logic [PtrW-1:0] AeLvl  = PtrW'(AE_LEVEL);
    localparam logic [PtrW-1:0] DepthC = PtrW'(DEPTH);

    // Elaboration-time parameter checks
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
        $fatal(1, "sync_fifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr, r_count;
    logic [PtrW-1:0]   w_wr_ptr_d, w_rd_ptr_d, w_count_d;
    logic              r_full, r_empty, r_af, r_ae, r_ovf, r_unf, r_rd_valid;
    logic              w_full_d, w_empty_d, w_af_d, w_ae_d, w_ovf_d, w_unf_d;
    logic              w_wr_ok, w_rd_ok, w_ovf_set, w_unf_set;
    logic [DATA_W-1:0] w_rdata;

    // A write at full is allowed when a read frees a slot in the same cycle.
    assign w_wr_ok   = fifo_bus.wr_en && (!r_full || fifo_bus.rd_en);
    assign w_rd_ok   = fifo_bus.rd_en && !r_empty;
    assign w_ovf_set = fifo_bus.wr_en && !w_wr_ok;
    assign w_unf_set = fifo_bus.rd_en && !w_rd_ok;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_count_d  = r_count;

        if (w_wr_ok) begin
            w_wr_ptr_d = r_wr_ptr + {{(PtrW-1){1'b0}}, 1'b1};
        end
        if (w_rd_ok) begin
            w_rd_ptr_d = r_rd_ptr + {{(PtrW-1){1'b0}}, 1'b1};
        end

        unique case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_d = r_count + {{(PtrW-1){1'b0}}, 1'b1};
            2'b01:   w_count_d = r_count - {{(PtrW-1){1'b0}}, 1'b1};
            default: w_count_d = r_count;
        endcase

        // Same address, opposite wrap bit: writer is a full lap ahead.
        w_full_d  = (w_wr_ptr_d[AddrW-1:0] == w_rd_ptr_d[AddrW-1:0]) &&
                    (w_wr_ptr_d[AddrW] != w_rd_ptr_d[AddrW]);
        w_empty_d = (w_wr_ptr_d == w_rd_ptr_d);
        w_af_d    = (w_count_d >= AfLvl);
        w_ae_d    = (w_count_d <= AeLvl);

`ifdef FIFO_STICKY_ERR_EN
        // Set dominates a simultaneous clear.
        w_ovf_d = w_ovf_set || (r_ovf && !fifo_bus.err_clr);
        w_unf_d = w_unf_set || (r_unf && !fifo_bus.err_clr);
`else
        w_ovf_d = w_ovf_set;
        w_unf_d = w_unf_set;
`endif
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_af       <= 1'b0;
            r_ae       <= 1'b1;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_count    <= w_count_d;
            r_full     <= w_full_d;
            r_empty    <= w_empty_d;
            r_af       <= w_af_d;
            r_ae       <= w_ae_d;
            r_ovf      <= w_ovf_d;
            r_unf      <= w_unf_d;
            r_rd_valid <= w_rd_ok;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (clk),
        .i_rst_n (res_n),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr[AddrW-1:0]),
        .i_wdata (fifo_bus.wdata),
        .i_re    (w_rd_ok),
        .i_raddr (r_rd_ptr[AddrW-1:0]),
        .o_rdata (w_rdata)
    );

    assign fifo_bus.rdata        = w_rdata;
    assign fifo_bus.rd_valid     = r_rd_valid;
    assign fifo_bus.full         = r_full;
    assign fifo_bus.empty        = r_empty;
    assign fifo_bus.almost_full  = r_af;
    assign fifo_bus.almost_empty = r_ae;
    assign fifo_bus.count        = r_count;
    assign fifo_bus.overflow     = r_ovf;
    assign fifo_bus.underflow    = r_unf;

    // DepthC kept for readability of the full/count relationship.
    if (DepthC == '0) begin : g_never
        $fatal(1, "sync_fifo_param: DEPTH does not fit count width");
    end

endmodule
